// File: rtl/vm_pkg.sv
// vm_pkg: shared coin codes, payment FSM encoding and price width for the vending datapath
package vm_pkg;
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1 = 2'b01;
   localparam logic [1:0] COIN_2 = 2'b10;
   localparam logic [1:0] COIN_3 = 2'b11;
   localparam int PRICE_W = 5;
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_PAYOUT} pay_state_t;
endpackage

// File: rtl/payment_controller_coin_decoder.sv
// coin_decoder: maps a coin code onto its credit value and a validity flag
module coin_decoder
   import vm_pkg::*;
#(
   parameter logic [PRICE_W-1:0] COIN1_VALUE = 5'd5,
   parameter logic [PRICE_W-1:0] COIN2_VALUE = 5'd10,
   parameter logic [PRICE_W-1:0] COIN3_VALUE = 5'd20
) (
   input  logic [1:0]         coin_i,
   output logic [PRICE_W-1:0] value_o,
   output logic               valid_o
);
   assign value_o = coin_i == COIN_1 ? COIN1_VALUE :
                    coin_i == COIN_2 ? COIN2_VALUE :
                    coin_i == COIN_3 ? COIN3_VALUE : '0;
   assign valid_o = coin_i != COIN_NONE;
endmodule

// File: rtl/payment_controller.sv
// payment_controller: accumulates coin credit, requests dispense once the price is
// covered, then pays out change, or refunds everything on cancel/inactivity timeout
module payment_controller
   import vm_pkg::*;
#(
   parameter logic [PRICE_W-1:0] COIN1_VALUE = 5'd5,
   parameter logic [PRICE_W-1:0] COIN2_VALUE = 5'd10,
   parameter logic [PRICE_W-1:0] COIN3_VALUE = 5'd20,
   parameter int CREDIT_W = 6,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin_in,
   input  logic                coin_valid,
   input  logic                cancel,
   input  logic                product_selector_done,
   input  logic [PRICE_W-1:0]  product_price,
   input  logic                product_dispense_done,
   output logic                product_dispense_en,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] change_out,
   output logic                change_valid,
   output logic                refund,
   output logic                coin_reject,
   output logic                busy
);
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   pay_state_t          state_q;
   logic [CREDIT_W-1:0] credit_q, change_q;
   logic [PRICE_W-1:0]  price_q;
   logic [TW-1:0]       timer_q;
   logic                dispense_q, change_valid_q, refund_q, reject_q;
   logic [PRICE_W-1:0]  coin_val;
   logic                coin_ok, abort, pay_ok, accept;
   logic [CREDIT_W:0]   sum;

   coin_decoder #(
      .COIN1_VALUE(COIN1_VALUE),
      .COIN2_VALUE(COIN2_VALUE),
      .COIN3_VALUE(COIN3_VALUE)
   ) u_dec (
      .coin_i (coin_in),
      .value_o(coin_val),
      .valid_o(coin_ok)
   );

   // carry out of the widened sum means the coin would push credit past MAX_CREDIT
   assign sum    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
   assign abort  = cancel || timer_q == T_LAST;
   assign pay_ok = product_selector_done && product_price != '0 && credit_q >= CREDIT_W'(product_price);
   assign accept = coin_valid && coin_ok && !sum[CREDIT_W] &&
                   (state_q == S_IDLE || (state_q == S_COLLECT && !abort && !pay_ok));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         change_q       <= '0;
         price_q        <= '0;
         timer_q        <= '0;
         dispense_q     <= 1'b0;
         change_valid_q <= 1'b0;
         refund_q       <= 1'b0;
         reject_q       <= 1'b0;
      end else begin
         change_valid_q <= 1'b0;
         refund_q       <= 1'b0;
         reject_q       <= coin_valid && !accept;
         if (accept) credit_q <= sum[CREDIT_W-1:0];
         case (state_q)
            S_IDLE: if (accept) begin
               state_q <= S_COLLECT;
               timer_q <= '0;
            end
            S_COLLECT: if (abort) begin
               state_q        <= S_PAYOUT;
               change_q       <= credit_q;
               change_valid_q <= 1'b1;
               refund_q       <= 1'b1;
               credit_q       <= '0;
            end else if (pay_ok) begin
               state_q    <= S_DISPENSE;
               price_q    <= product_price;
               dispense_q <= 1'b1;
            end else begin
               timer_q <= accept ? '0 : timer_q + 1'b1;
            end
            S_DISPENSE: if (product_dispense_done) begin
               state_q        <= S_PAYOUT;
               dispense_q     <= 1'b0;
               change_q       <= credit_q - CREDIT_W'(price_q);
               change_valid_q <= 1'b1;
               credit_q       <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign product_dispense_en = dispense_q;
   assign credit              = credit_q;
   assign change_out          = change_q;
   assign change_valid        = change_valid_q;
   assign refund              = refund_q;
   assign coin_reject         = reject_q;
   assign busy                = state_q != S_IDLE;
endmodule

// File: tb/tb_payment_controller.sv
// tb_payment_controller: directed vectors with a scoreboard of expected payouts,
// coin rejects and dispense requests, each tagged with the clock edge it must follow
module tb_payment_controller;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] coin_in = '0;
   logic       coin_valid = 1'b0, cancel = 1'b0, psd = 1'b0, ddone = 1'b0;
   logic [4:0] price = '0;
   logic       dispense, change_valid, refund, coin_reject, busy;
   logic [5:0] credit, change_out;

   typedef struct {int at; int change; int refund;} pay_t;
   pay_t pay_q[$];
   int   rej_q[$];
   int   disp_q[$];
   pay_t pe;
   int   edges = 0, n_vec = 0, n_bad = 0;
   logic prev_disp = 1'b0;

   payment_controller #(.CREDIT_W(6), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .coin_in(coin_in), .coin_valid(coin_valid), .cancel(cancel),
      .product_selector_done(psd), .product_price(price), .product_dispense_done(ddone),
      .product_dispense_en(dispense), .credit(credit), .change_out(change_out),
      .change_valid(change_valid), .refund(refund), .coin_reject(coin_reject), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic coin(logic [1:0] c, bit rej);
      coin_in = c;
      coin_valid = 1'b1;
      if (rej) rej_q.push_back(edges + 1);
      tick(1);
      coin_valid = 1'b0;
      coin_in = '0;
   endtask

   task automatic expect_pay(int at, int ch, int rf);
      pay_t p;
      p.at = at;
      p.change = ch;
      p.refund = rf;
      pay_q.push_back(p);
   endtask

   // monitor: every observed output event must match the next scoreboard entry
   always @(negedge clk) begin
      if (change_valid) begin
         chk("payout_expected", 32'(pay_q.size() > 0), 1);
         if (pay_q.size() > 0) begin
            pe = pay_q.pop_front();
            chk("payout_edge", edges, pe.at);
            chk("change_out", 32'(change_out), pe.change);
            chk("refund", 32'(refund), pe.refund);
            chk("credit_at_payout", 32'(credit), 0);
         end
      end
      if (coin_reject) begin
         chk("reject_expected", 32'(rej_q.size() > 0), 1);
         if (rej_q.size() > 0) chk("reject_edge", edges, rej_q.pop_front());
      end
      if (dispense && !prev_disp) begin
         chk("dispense_expected", 32'(disp_q.size() > 0), 1);
         if (disp_q.size() > 0) chk("dispense_edge", edges, disp_q.pop_front());
      end
      prev_disp = dispense;
   end

   initial begin
      tick(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_credit", 32'(credit), 0);
      chk("rst_dispense", 32'(dispense), 0);
      chk("rst_change_out", 32'(change_out), 0);
      rst = 1'b0;
      tick(1);

      // price 15: 10 + 5, exact change 0
      price = 5'd15; psd = 1'b1;
      coin(2'b10, 0);
      chk("t1_credit10", 32'(credit), 10);
      coin(2'b01, 0);
      chk("t1_credit15", 32'(credit), 15);
      chk("t1_no_disp_yet", 32'(dispense), 0);
      disp_q.push_back(edges + 1);
      tick(1);
      ddone = 1'b1;
      expect_pay(edges + 1, 0, 0);
      tick(1);
      ddone = 1'b0; psd = 1'b0;
      tick(1);
      chk("t1_idle", 32'(busy), 0);

      // price 25: 20 + 20, change 15, dispense held until done
      price = 5'd25; psd = 1'b1;
      coin(2'b11, 0);
      coin(2'b11, 0);
      chk("t2_credit40", 32'(credit), 40);
      disp_q.push_back(edges + 1);
      tick(4);
      chk("t2_disp_held", 32'(dispense), 1);
      chk("t2_busy", 32'(busy), 1);
      ddone = 1'b1;
      expect_pay(edges + 1, 15, 0);
      tick(1);
      ddone = 1'b0; psd = 1'b0;
      tick(1);
      chk("t2_idle", 32'(busy), 0);
      chk("t2_credit0", 32'(credit), 0);

      // cancel beats a simultaneous coin; refund excludes it
      coin(2'b10, 0);
      cancel = 1'b1; coin_in = 2'b01; coin_valid = 1'b1;
      rej_q.push_back(edges + 1);
      expect_pay(edges + 1, 10, 1);
      tick(1);
      cancel = 1'b0; coin_in = '0; coin_valid = 1'b0;
      tick(1);
      chk("t3_idle", 32'(busy), 0);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      tick(1);
      chk("t3_cancel_idle_ignored", 32'(busy), 0);

      // inactivity timeout after 8 idle edges
      coin(2'b01, 0);
      expect_pay(edges + 8, 5, 1);
      tick(7);
      chk("t4_still_busy", 32'(busy), 1);
      tick(3);
      chk("t4_idle", 32'(busy), 0);

      // saturation at 60 and coin during dispense
      coin(2'b11, 0);
      coin(2'b11, 0);
      coin(2'b11, 0);
      chk("t5_credit60", 32'(credit), 60);
      coin(2'b01, 1);
      chk("t5_sat_credit", 32'(credit), 60);
      price = 5'd31; psd = 1'b1;
      disp_q.push_back(edges + 1);
      tick(1);
      coin(2'b10, 1);
      chk("t5_disp_coin_credit", 32'(credit), 60);
      ddone = 1'b1;
      expect_pay(edges + 1, 29, 0);
      tick(1);
      ddone = 1'b0; psd = 1'b0;
      tick(1);

      // coin arriving on the edge the price compare passes is rejected
      coin(2'b10, 0);
      price = 5'd10; psd = 1'b1; coin_in = 2'b01; coin_valid = 1'b1;
      disp_q.push_back(edges + 1);
      rej_q.push_back(edges + 1);
      tick(1);
      coin_in = '0; coin_valid = 1'b0;
      chk("t7_credit10", 32'(credit), 10);
      ddone = 1'b1;
      expect_pay(edges + 1, 0, 0);
      tick(1);
      ddone = 1'b0; psd = 1'b0;
      tick(1);

      // reset during dispense: no payout, everything cleared
      price = 5'd5; psd = 1'b1;
      coin(2'b11, 0);
      disp_q.push_back(edges + 1);
      tick(1);
      chk("t6_in_dispense", 32'(dispense), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0; psd = 1'b0;
      chk("t6_dispense0", 32'(dispense), 0);
      chk("t6_busy0", 32'(busy), 0);
      chk("t6_credit0", 32'(credit), 0);
      chk("t6_change_out0", 32'(change_out), 0);
      chk("t6_valid0", 32'(change_valid), 0);
      tick(3);

      chk("pay_q_drained", pay_q.size(), 0);
      chk("rej_q_drained", rej_q.size(), 0);
      chk("disp_q_drained", disp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
